avalon_mem_arbiter: RTL

Shares the CPU's single Avalon master port between the instruction-fetch (IF) requester and the data-memory (MEM) requester of the pipelined CPU. Serialises accesses, holds bus signals stable across waitrequest, and returns one-cycle acks with registered read data that the pipeline uses as stall release. Also bounds waitrequest stalls with a timeout that reports a bus error.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_wait_timer.sv | 30 +++
 rtl/avalon_mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the Avalon memory arbiter: FSM states, grant identifiers
// and the all-ones byte-enable used for instruction fetches.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // Wide enough for any supported DATA_W; users slice the low DATA_W/8 bits.
  localparam int unsigned        BE_MAX_W = 64;
  localparam logic [BE_MAX_W-1:0] BE_ALL  = '1;

endpackage

// File: rtl/arb_wait_timer.sv
// Waitrequest stall counter. term_o flags that the current wait cycle is the
// one that brings the count to LIMIT, so the owner can abort on that cycle.
module arb_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon master between the IF and MEM requesters with registered
// outputs and a waitrequest timeout. Define ARB_ROUND_ROBIN_EN for round-robin.
module avalon_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteen,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   write_data,
  output logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                waitrequest
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d, write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              cnt_clr, cnt_en, cnt_term;
  grant_e            win;
`ifdef ARB_ROUND_ROBIN_EN
  grant_e            last_q, last_d;
`endif

  arb_wait_timer #(.LIMIT(WAIT_LIMIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_o (cnt_term)
  );

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) win = (last_q == GNT_MEM) ? GNT_IF : GNT_MEM;
    else                win = d_req ? GNT_MEM : GNT_IF;
`else
    win = d_req ? GNT_MEM : GNT_IF;
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    read_d    = read_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_d = win;
`endif
          if (win == GNT_MEM) begin
            state_d = BUS_D;
            addr_d  = d_addr;
            read_d  = ~d_we;
            write_d = d_we;
            wdata_d = d_wdata;
            be_d    = d_byteen;
          end else begin
            state_d = BUS_I;
            addr_d  = i_addr;
            read_d  = 1'b1;
            write_d = 1'b0;
            wdata_d = '0;
            be_d    = BE_ALL[BE_W-1:0];
          end
        end
      end
      BUS_I, BUS_D: begin
        // Completion wins over timeout when both land on the same cycle.
        if (!waitrequest || cnt_term) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          err_d   = waitrequest;
          state_d = RESP;
          if (state_q == BUS_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = waitrequest ? '0 : read_data;
          end else begin
            d_ack_d = 1'b1;
            if (read_q) d_rdata_d = waitrequest ? '0 : read_data;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= GNT_IF;
    else      last_q <= last_d;
  end
`endif

  assign address    = addr_q;
  assign read       = read_q;
  assign write      = write_q;
  assign write_data = wdata_q;
  assign byte_en    = be_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign bus_err    = err_q;
  assign busy       = busy_q;

endmodule
